matmul_share_scheduler: RTL and testbench



---
 rtl/matmul_sched_pkg.sv | 24 ++
 rtl/matmul_share_scheduler_rr_arbiter.sv | 33 +++
 rtl/matmul_share_scheduler.sv | 115 +++++++++++
 tb/tb_matmul_share_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sched_pkg.sv
// Shared defaults, index-width helper and the tag carried alongside each
// multiplier operation.
package matmul_sched_pkg;

  localparam int W_DEF           = 16;
  localparam int D_DEF           = 8;
  localparam int MUL_LATENCY_DEF = 4;
  localparam int N_MAX           = 8;

  // Bits needed to name one of n requesters (n is 2..8).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Tags are sized for the largest supported requester count so the type
  // can live here; narrower configurations zero-extend into idx.
  localparam int IDX_W = idx_w(N_MAX);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/matmul_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first eligible index at or above
// rr_ptr (wrapping) wins. The pointer itself is owned by the caller.
module rr_arbiter
  import matmul_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest eligible index
  // is the last writer and therefore the winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr) + off) % N;
      if (elig[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/matmul_share_scheduler.sv
// Shares one fixed-latency row-by-matrix multiplier among N requesters.
// Each requester has at most one operation outstanding; a tag pipeline
// matched to the multiplier latency steers each result to its owner.
module matmul_share_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = W_DEF,
  parameter int D           = D_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*D*W-1:0]     packed_req_a,
  output logic [D*W-1:0]       mul_a,
  input  logic [2*D*W-1:0]     mul_out,
  input  logic                 mul_out_v,
  output logic [N-1:0]         rsp_valid,
  input  logic [N-1:0]         rsp_ready,
  output logic [N*2*D*W-1:0]   packed_rsp,
  output logic                 err
);

  localparam int IW = idx_w(N);
  localparam int RW = D * W;
  localparam int OW = 2 * D * W;

  logic [N-1:0]  busy;
  logic [N-1:0]  elig;
  logic [N-1:0]  grant;
  logic [N-1:0]  fire;
  logic          any_fire;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  tag_t          tag_pipe [MUL_LATENCY+1];
  tag_t          tail;

  assign elig      = req_valid & ~busy;
  assign req_ready = grant;
  assign fire      = req_valid & grant;
  assign any_fire  = |fire;
  assign tail      = tag_pipe[MUL_LATENCY];

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Issue: latch the winner's row into the multiplier and advance the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a  <= '0;
      rr_ptr <= '0;
    end else if (any_fire) begin
      mul_a  <= packed_req_a[int'(grant_idx)*RW +: RW];
      rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tag pipeline: tail lines up with the cycle mul_out reflects the issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= MUL_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: any_fire, idx: IDX_W'(grant_idx)};
      for (int s = 1; s <= MUL_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // Sticky flag: a result was due but the multiplier did not mark it valid.
  always_ff @(posedge clk) begin
    if (rst)                          err <= 1'b0;
    else if (tail.valid && !mul_out_v) err <= 1'b1;
  end

  for (genvar k = 0; k < N; k++) begin : g_req
    logic          cap;
    logic          hs;
    logic          busy_q;
    logic          rv_q;
    logic [OW-1:0] rsp_q;

    assign cap = tail.valid && (tail.idx == IDX_W'(k));
    assign hs  = rv_q && rsp_ready[k];

    // Per-requester ownership: busy from issue until the result is consumed.
    always_ff @(posedge clk) begin
      if (rst) begin
        busy_q <= 1'b0;
        rv_q   <= 1'b0;
        rsp_q  <= '0;
      end else begin
        if (fire[k])  busy_q <= 1'b1;
        else if (hs)  busy_q <= 1'b0;
        if (cap)      rv_q   <= 1'b1;
        else if (hs)  rv_q   <= 1'b0;
        if (cap)      rsp_q  <= mul_out;
      end
    end

    // A capture can never land on an unconsumed result because busy blocks re-issue.
    always_ff @(posedge clk) begin
      if (!rst) a_no_collide: assert (!(cap && rv_q));
    end

    assign busy[k]                 = busy_q;
    assign rsp_valid[k]            = rv_q;
    assign packed_rsp[k*OW +: OW]  = rsp_q;
  end

endmodule

// File: tb/tb_matmul_share_scheduler.sv
// Directed bench for matmul_share_scheduler with an identity-weight
// multiplier model and a per-issue scoreboard of expected results.
module tb_matmul_share_scheduler;
  import matmul_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int L  = 4;
  localparam int RW = D * W;
  localparam int OW = 2 * D * W;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*RW-1:0]   packed_req_a;
  logic [RW-1:0]     mul_a;
  logic [OW-1:0]     mul_out;
  logic              mul_out_v;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [N*OW-1:0]   packed_rsp;
  logic              err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  matmul_share_scheduler #(.N(N), .W(W), .D(D), .MUL_LATENCY(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .packed_req_a (packed_req_a),
    .mul_a        (mul_a),
    .mul_out      (mul_out),
    .mul_out_v    (mul_out_v),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .packed_rsp   (packed_rsp),
    .err          (err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Identity weights: each output element is the input element sign-extended.
  function automatic logic [OW-1:0] sext(input logic [RW-1:0] r);
    logic [OW-1:0] o;
    o = '0;
    for (int j = 0; j < D; j++)
      o[j*2*W +: 2*W] = {{W{r[j*W+W-1]}}, r[j*W +: W]};
    return o;
  endfunction

  function automatic logic [RW-1:0] mk_row(input int s);
    logic [RW-1:0] r;
    int e;
    r = '0;
    for (int j = 0; j < D; j++) begin
      e = s * 8 + j + 1;
      if (s % 2 == 1) e = -e;
      r[j*W +: W] = W'(e);
    end
    return r;
  endfunction

  // Multiplier model: L-cycle delay line from mul_a.
  logic [RW-1:0] mpipe [L];
  logic          mv_kill = 1'b0;
  always @(posedge clk) begin
    mpipe[0] <= mul_a;
    for (int j = 1; j < L; j++) mpipe[j] <= mpipe[j-1];
  end
  assign mul_out   = sext(mpipe[L-1]);
  assign mul_out_v = !mv_kill;

  typedef struct {
    int            idx;
    logic [OW-1:0] data;
    int            due;
  } exp_t;
  exp_t         sb[$];
  logic [N-1:0] prev_rv = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on each issue, pop and compare on each rising rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    int   pos;
    if (rst) begin
      sb.delete();
      prev_rv <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          e.idx  = k;
          e.data = sext(packed_req_a[k*RW +: RW]);
          e.due  = cyc + L + 2;
          sb.push_back(e);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (rsp_valid[k] && !prev_rv[k]) begin
          pos = -1;
          for (int q = 0; q < sb.size(); q++) if (sb[q].idx == k) pos = q;
          chk("rsp_expected", 32'(pos >= 0), 32'd1);
          if (pos >= 0) begin
            chk("rsp_cycle", 32'(cyc), 32'(sb[pos].due));
            checks++;
            assert (packed_rsp[k*OW +: OW] === sb[pos].data) else begin
              failures++;
              $error("FAIL rsp_data idx=%0d observed=%0h expected=%0h",
                     k, packed_rsp[k*OW +: OW], sb[pos].data);
            end
            sb.delete(pos);
          end
        end
      end
      prev_rv <= rsp_valid;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int i, input logic [RW-1:0] r);
    packed_req_a[i*RW +: RW] = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int gcount;
    logic [N-1:0] exp_oh;

    rst = 1'b1; req_valid = '0; rsp_ready = '0; packed_req_a = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mul_a", 32'(|mul_a), 32'd0);
    chk("rst_packed_rsp", 32'(|packed_rsp), 32'd0);

    // 1: single request, result held while rsp_ready is low
    next(); set_row(0, mk_row(0)); req_valid = 4'b0001; c0 = cyc;
    @(negedge clk); chk("t1_ready", 32'(req_ready), 32'h1);
    for (int i = 1; i < 6; i++) begin
      next(); @(negedge clk);
      chk("t1_busy_ready", 32'(req_ready), 32'h0);
      chk("t1_no_rsp", 32'(rsp_valid), 32'h0);
    end
    next(); @(negedge clk);
    chk("t1_rsp_cycle", 32'(cyc - c0), 32'd6);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_elem0", packed_rsp[31:0], 32'd1);
    chk("t1_elem7", packed_rsp[7*32 +: 32], 32'd8);
    for (int i = 0; i < 3; i++) begin
      next(); @(negedge clk);
      chk("t1_hold_valid", 32'(rsp_valid), 32'h1);
      chk("t1_hold_ready", 32'(req_ready), 32'h0);
      chk("t1_hold_elem7", packed_rsp[7*32 +: 32], 32'd8);
    end
    next(); req_valid = '0; rsp_ready = 4'b0001;
    @(negedge clk); chk("t1_hs_valid", 32'(rsp_valid), 32'h1);
    next(); rsp_ready = '0;
    @(negedge clk);
    chk("t1_cleared", 32'(rsp_valid), 32'h0);
    chk("t1_data_kept", packed_rsp[31:0], 32'd1);

    // 2: all four from reset, issued in index order
    next(); rst = 1'b1;
    next(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_row(i, mk_row(i + 1));
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      if (i > 0) next();
      @(negedge clk); chk("t2_grant", 32'(req_ready), 32'(1 << i));
    end
    for (int i = 4; i < 6; i++) begin
      next(); @(negedge clk); chk("t2_idle", 32'(req_ready), 32'h0);
    end
    for (int i = 0; i < N; i++) begin
      next(); @(negedge clk); chk("t2_rsp_rise", 32'(rsp_valid), 32'((1 << (i + 1)) - 1));
    end
    next(); req_valid = '0; rsp_ready = 4'b1111;
    @(negedge clk); chk("t2_rsp_all", 32'(rsp_valid), 32'hf);
    next(); rsp_ready = '0;
    @(negedge clk); chk("t2_drained", 32'(rsp_valid), 32'h0);

    // 3: requesters 0 and 2 always valid, consumers always ready
    next(); req_valid = 4'b0101; rsp_ready = 4'b1111;
    exp_oh = 4'b0001; gcount = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) next();
      @(negedge clk);
      chk("t3_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (req_ready != '0) begin
        chk("t3_alternate", 32'(req_ready), 32'(exp_oh));
        exp_oh = (exp_oh == 4'b0001) ? 4'b0100 : 4'b0001;
        gcount++;
      end
    end
    chk("t3_grant_count", 32'(gcount), 32'd10);
    next(); req_valid = '0;
    repeat (10) next();
    @(negedge clk); chk("t3_drained", 32'(rsp_valid), 32'h0);

    // 4: re-issue timing for requester 1, then pointer-driven choice
    next(); req_valid = 4'b0010; rsp_ready = '0;
    @(negedge clk); chk("t4_fire", 32'(req_ready), 32'h2);
    repeat (7) next();
    @(negedge clk);
    chk("t4_rsp", 32'(rsp_valid), 32'h2);
    chk("t4_busy", 32'(req_ready), 32'h0);
    next(); rsp_ready = 4'b0010;
    @(negedge clk); chk("t4_ready_t", 32'(req_ready), 32'h0);
    next(); rsp_ready = 4'b1111;
    @(negedge clk);
    chk("t4_ready_t1", 32'(req_ready), 32'h2);
    chk("t4_rsp_gone", 32'(rsp_valid), 32'h0);
    next(); req_valid = 4'b0101;
    @(negedge clk); chk("t4_rr_from_ptr", 32'(req_ready), 32'h4);
    next();
    @(negedge clk); chk("t4_rr_wrap", 32'(req_ready), 32'h1);
    next(); req_valid = '0;
    repeat (10) next();
    @(negedge clk); chk("t4_drained", 32'(rsp_valid), 32'h0);

    // 5: reset with two operations in flight
    next(); req_valid = 4'b0011; rsp_ready = '0;
    @(negedge clk); chk("t5_fire1", 32'(req_ready), 32'h2);
    next();
    @(negedge clk); chk("t5_fire0", 32'(req_ready), 32'h1);
    next(); req_valid = '0;
    next(); rst = 1'b1;
    next(); rst = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t5_mul_a", 32'(|mul_a), 32'd0);
    chk("t5_packed_rsp", 32'(|packed_rsp), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < 8; i++) begin
      next(); @(negedge clk); chk("t5_no_late_rsp", 32'(rsp_valid), 32'h0);
    end
    next(); req_valid = 4'b1111;
    @(negedge clk); chk("t5_ptr_restart", 32'(req_ready), 32'h1);
    next(); req_valid = '0; rsp_ready = 4'b1111;
    repeat (10) next();

    // 6: missing mul_out_v at capture sets sticky err
    rsp_ready = '0; req_valid = 4'b1000; mv_kill = 1'b1;
    @(negedge clk); chk("t6_fire", 32'(req_ready), 32'h8);
    next(); req_valid = '0;
    @(negedge clk); chk("t6_err_early", 32'(err), 32'd0);
    repeat (4) next();
    @(negedge clk); chk("t6_err_before", 32'(err), 32'd0);
    next();
    @(negedge clk);
    chk("t6_err_set", 32'(err), 32'd1);
    chk("t6_rsp_delivered", 32'(rsp_valid), 32'h8);
    next(); mv_kill = 1'b0; rsp_ready = 4'b1111;
    repeat (5) next();
    @(negedge clk);
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk("t6_consumed", 32'(rsp_valid), 32'h0);
    next(); rst = 1'b1;
    next(); rst = 1'b0;
    @(negedge clk); chk("t6_err_cleared", 32'(err), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
